ps2_kbd_ctrl: RTL and testbench

- Scan-code sequencer sitting directly behind the PS/2 byte receiver.
- Consumes the receiver's one-cycle byte strobe and byte.
- Tracks the Set-2 prefix sequences (E0 extended, F0 break, E1 pause).
- Emits one decoded key event per complete sequence into a small first-word-fall-through event FIFO for the CPU or UI logic, with an inter-byte timeout and error/status reporting.

---
 rtl/ps2_kbd_ctrl.sv | 259 +++++++++++++++++++++++++
 tb/tb_ps2_kbd_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_kbd_ctrl.sv
// ps2_kbd_ctrl - PS/2 Set-2 scan-code sequencer with event FIFO.
//
// Sits behind a PS/2 byte receiver. Tracks E0 (extended), F0 (break) and
// E1 (pause) prefix sequences and queues one decoded key event per complete
// sequence into a first-word-fall-through FIFO. Keyboard status bytes are
// reported on sys_pulse/sys_code. An inter-byte timeout aborts stalled
// sequences.
//
// Optional build macro: PS2_KBD_TYPEMATIC_FILTER_EN
//   When defined, repeated make codes of the currently held key are dropped.
//
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   ps2_done   one-cycle strobe, ps2_data holds a new byte
//   ps2_data   received byte
//   evt_rd     pop head event (ignored when empty)
//   evt_valid  FIFO non-empty
//   evt_code   head event scan code
//   evt_ext    head event had E0 prefix
//   evt_brk    head event is a release
//   evt_cnt    number of queued events
//   sys_pulse  one-cycle pulse, status byte received
//   sys_code   last status byte
//   ovf        sticky overflow flag (event dropped, FIFO full)
//   tmo        one-cycle pulse, sequence aborted by timeout
//   clr_err    clears ovf
module ps2_kbd_ctrl #(
  parameter int unsigned TIMEOUT_CYC = 50000,
  parameter int unsigned FIFO_AW     = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ps2_done,
  input  logic [7:0]         ps2_data,
  input  logic               evt_rd,
  output logic               evt_valid,
  output logic [7:0]         evt_code,
  output logic               evt_ext,
  output logic               evt_brk,
  output logic [FIFO_AW:0]   evt_cnt,
  output logic               sys_pulse,
  output logic [7:0]         sys_code,
  output logic               ovf,
  output logic               tmo,
  input  logic               clr_err
);

  localparam int unsigned DEPTH = 1 << FIFO_AW;
  localparam int unsigned TW    = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_E0,
    S_F0,
    S_E0F0,
    S_E1
  } state_t;

  state_t          state, state_nxt;
  logic [2:0]      skip, skip_nxt;
  logic [TW-1:0]   tmo_cnt;

  logic            push, push_ext, push_brk;
  logic [7:0]      push_code;
  logic            push_q;
  logic            sys_set;
  logic            tmo_fire;

  logic [9:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic               full, pop_ok, wr_ok, ovf_set;

  function automatic logic is_status(input logic [7:0] b);
    case (b)
      8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'hFC, 8'h00, 8'hFF: is_status = 1'b1;
      default:                                         is_status = 1'b0;
    endcase
  endfunction

  function automatic logic is_prefix(input logic [7:0] b);
    is_prefix = (b == 8'hE0) || (b == 8'hF0) || (b == 8'hE1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      skip  <= '0;
    end else begin
      state <= state_nxt;
      skip  <= skip_nxt;
    end
  end

  // The timeout fires on the edge where the counter would reach
  // TIMEOUT_CYC-1, i.e. TIMEOUT_CYC-1 cycles after the last accepted byte.
  always_comb begin
    state_nxt = state;
    skip_nxt  = skip;
    push      = 1'b0;
    push_ext  = 1'b0;
    push_brk  = 1'b0;
    push_code = ps2_data;
    sys_set   = 1'b0;
    tmo_fire  = 1'b0;
    if (ps2_done) begin
      case (state)
        S_IDLE: begin
          if (ps2_data == 8'hE0) begin
            state_nxt = S_E0;
          end else if (ps2_data == 8'hF0) begin
            state_nxt = S_F0;
          end else if (ps2_data == 8'hE1) begin
            state_nxt = S_E1;
            skip_nxt  = 3'd7;
          end else if (is_status(ps2_data)) begin
            sys_set = 1'b1;
          end else begin
            push = 1'b1;
          end
        end
        S_E0: begin
          if (ps2_data == 8'hF0) begin
            state_nxt = S_E0F0;
          end else if (ps2_data != 8'hE0 && ps2_data != 8'hE1) begin
            push      = 1'b1;
            push_ext  = 1'b1;
            state_nxt = S_IDLE;
          end
        end
        S_F0: begin
          state_nxt = S_IDLE;
          if (!is_prefix(ps2_data)) begin
            push     = 1'b1;
            push_brk = 1'b1;
          end
        end
        S_E0F0: begin
          state_nxt = S_IDLE;
          if (!is_prefix(ps2_data)) begin
            push     = 1'b1;
            push_ext = 1'b1;
            push_brk = 1'b1;
          end
        end
        S_E1: begin
          skip_nxt = skip - 3'd1;
          if (skip == 3'd1) begin
            push      = 1'b1;
            push_ext  = 1'b1;
            push_code = 8'hE1;
            state_nxt = S_IDLE;
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end else if (state != S_IDLE && tmo_cnt == TW'(TIMEOUT_CYC - 2)) begin
      tmo_fire  = 1'b1;
      state_nxt = S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || ps2_done || state == S_IDLE || tmo_fire) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + TW'(1);
    end
  end

`ifdef PS2_KBD_TYPEMATIC_FILTER_EN
  logic       lm_valid, lm_valid_nxt;
  logic       lm_ext, lm_ext_nxt;
  logic [7:0] lm_code, lm_code_nxt;
  logic       lm_hit;

  assign lm_hit = lm_valid && (lm_ext == push_ext) && (lm_code == push_code);

  always_comb begin
    lm_valid_nxt = lm_valid;
    lm_ext_nxt   = lm_ext;
    lm_code_nxt  = lm_code;
    push_q       = push;
    if (tmo_fire) begin
      lm_valid_nxt = 1'b0;
    end else if (push) begin
      if (push_brk) begin
        if (lm_hit) lm_valid_nxt = 1'b0;
      end else if (lm_hit) begin
        push_q = 1'b0;
      end else begin
        lm_valid_nxt = 1'b1;
        lm_ext_nxt   = push_ext;
        lm_code_nxt  = push_code;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lm_valid <= 1'b0;
      lm_ext   <= 1'b0;
      lm_code  <= '0;
    end else begin
      lm_valid <= lm_valid_nxt;
      lm_ext   <= lm_ext_nxt;
      lm_code  <= lm_code_nxt;
    end
  end
`else
  assign push_q = push;
`endif

  // A pop in the same cycle frees a slot, so a push into a full FIFO with a
  // concurrent pop is accepted.
  assign full    = (evt_cnt == (FIFO_AW + 1)'(DEPTH));
  assign pop_ok  = evt_rd && (evt_cnt != '0);
  assign wr_ok   = push_q && (!full || pop_ok);
  assign ovf_set = push_q && full && !pop_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      evt_cnt <= '0;
    end else begin
      if (wr_ok) begin
        mem[wr_ptr] <= {push_ext, push_brk, push_code};
        wr_ptr      <= wr_ptr + FIFO_AW'(1);
      end
      if (pop_ok) rd_ptr <= rd_ptr + FIFO_AW'(1);
      case ({wr_ok, pop_ok})
        2'b10:   evt_cnt <= evt_cnt + (FIFO_AW + 1)'(1);
        2'b01:   evt_cnt <= evt_cnt - (FIFO_AW + 1)'(1);
        default: evt_cnt <= evt_cnt;
      endcase
    end
  end

  assign evt_valid = (evt_cnt != '0);
  assign {evt_ext, evt_brk, evt_code} = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      sys_pulse <= 1'b0;
      sys_code  <= '0;
      tmo       <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      sys_pulse <= sys_set;
      tmo       <= tmo_fire;
      if (sys_set) sys_code <= ps2_data;
      if (ovf_set)      ovf <= 1'b1;
      else if (clr_err) ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
module tb_ps2_kbd_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_done = 1'b0;
  logic [7:0] ps2_data = '0;
  logic       evt_rd = 1'b0;
  logic       clr_err = 1'b0;
  logic       evt_valid;
  logic [7:0] evt_code;
  logic       evt_ext;
  logic       evt_brk;
  logic [2:0] evt_cnt;
  logic       sys_pulse;
  logic [7:0] sys_code;
  logic       ovf;
  logic       tmo;

  int tests = 0;
  int fails = 0;
  int sys_seen = 0;
  int tmo_seen = 0;
  int both_seen = 0;

  always #5 clk = ~clk;

  ps2_kbd_ctrl #(.TIMEOUT_CYC(16), .FIFO_AW(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .ps2_done  (ps2_done),
    .ps2_data  (ps2_data),
    .evt_rd    (evt_rd),
    .evt_valid (evt_valid),
    .evt_code  (evt_code),
    .evt_ext   (evt_ext),
    .evt_brk   (evt_brk),
    .evt_cnt   (evt_cnt),
    .sys_pulse (sys_pulse),
    .sys_code  (sys_code),
    .ovf       (ovf),
    .tmo       (tmo),
    .clr_err   (clr_err)
  );

  always @(negedge clk) begin
    if (sys_pulse) sys_seen++;
    if (tmo) tmo_seen++;
    if (sys_pulse && tmo) both_seen++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    ps2_done = 1'b1;
    ps2_data = b;
    @(negedge clk);
    ps2_done = 1'b0;
  endtask

  task automatic gap(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pop_chk(input string tag, input logic ext, input logic brk, input logic [7:0] code);
    chk({tag, "_valid"}, 32'(evt_valid), 32'd1);
    chk({tag, "_code"}, 32'(evt_code), 32'(code));
    chk({tag, "_ext"}, 32'(evt_ext), 32'(ext));
    chk({tag, "_brk"}, 32'(evt_brk), 32'(brk));
    @(negedge clk);
    evt_rd = 1'b1;
    @(negedge clk);
    evt_rd = 1'b0;
  endtask

  initial begin
    int wait_cyc;
    int tmo_before;

    // reset
    gap(3);
    rst = 1'b0;
    chk("rst_valid", 32'(evt_valid), 32'd0);
    chk("rst_cnt", 32'(evt_cnt), 32'd0);
    chk("rst_code", 32'(evt_code), 32'd0);
    chk("rst_ext_brk", 32'({evt_ext, evt_brk}), 32'd0);
    chk("rst_sys", 32'({sys_pulse, sys_code}), 32'd0);
    chk("rst_ovf_tmo", 32'({ovf, tmo}), 32'd0);

    // make then break
    send(8'h1C);
    chk("lat_valid", 32'(evt_valid), 32'd1);
    gap(3);
    send(8'hF0);
    gap(3);
    send(8'h1C);
    chk("mb_cnt", 32'(evt_cnt), 32'd2);
    chk("mb_nosys", 32'(sys_seen), 32'd0);
    pop_chk("mb_make", 1'b0, 1'b0, 8'h1C);
    pop_chk("mb_brk", 1'b0, 1'b1, 8'h1C);
    chk("mb_empty", 32'(evt_cnt), 32'd0);

    // extended make / break
    send(8'hE0); gap(2); send(8'h75);
    gap(2);
    send(8'hE0); gap(2); send(8'hF0); gap(2); send(8'h75);
    chk("ext_cnt", 32'(evt_cnt), 32'd2);
    pop_chk("ext_make", 1'b1, 1'b0, 8'h75);
    pop_chk("ext_brk", 1'b1, 1'b1, 8'h75);

    // status byte
    send(8'hAA);
    chk("sys_pulse", 32'(sys_pulse), 32'd1);
    chk("sys_code", 32'(sys_code), 32'hAA);
    gap(1);
    chk("sys_pulse_off", 32'(sys_pulse), 32'd0);
    chk("sys_code_hold", 32'(sys_code), 32'hAA);
    chk("sys_noevt", 32'(evt_cnt), 32'd0);

    // pause sequence
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0);
    chk("pause_pending", 32'(evt_cnt), 32'd0);
    send(8'h77);
    chk("pause_cnt", 32'(evt_cnt), 32'd1);
    pop_chk("pause", 1'b1, 1'b0, 8'hE1);
    send(8'h1C);
    pop_chk("post_pause", 1'b0, 1'b0, 8'h1C);

    // timeout after F0
    tmo_before = tmo_seen;
    send(8'hF0);
    wait_cyc = 0;
    while (wait_cyc < 40 && !tmo) begin
      @(negedge clk);
      wait_cyc++;
    end
    chk("tmo_delay", 32'(wait_cyc), 32'd15);
    chk("tmo_no_sys", 32'(sys_pulse), 32'd0);
    gap(1);
    chk("tmo_one_cycle", 32'(tmo), 32'd0);
    chk("tmo_count", 32'(tmo_seen - tmo_before), 32'd1);
    chk("tmo_nopush", 32'(evt_cnt), 32'd0);
    gap(4);
    send(8'h1C);
    pop_chk("tmo_after", 1'b0, 1'b0, 8'h1C);

    // byte on the timeout cycle wins
    tmo_before = tmo_seen;
    send(8'hF0);
    gap(13);
    send(8'h1C);
    gap(20);
    chk("tmo_race_none", 32'(tmo_seen - tmo_before), 32'd0);
    chk("tmo_race_cnt", 32'(evt_cnt), 32'd1);
    pop_chk("tmo_race", 1'b0, 1'b1, 8'h1C);

    // overflow
    send(8'h15); send(8'h1D); send(8'h24); send(8'h2D);
    chk("full_noovf", 32'(ovf), 32'd0);
    send(8'h2C);
    chk("ovf_cnt", 32'(evt_cnt), 32'd4);
    chk("ovf_set", 32'(ovf), 32'd1);
    chk("ovf_head", 32'(evt_code), 32'h15);
    @(negedge clk); clr_err = 1'b1;
    @(negedge clk); clr_err = 1'b0;
    chk("ovf_clr", 32'(ovf), 32'd0);
    // pop and push together while full
    @(negedge clk);
    evt_rd = 1'b1; ps2_done = 1'b1; ps2_data = 8'h35;
    @(negedge clk);
    evt_rd = 1'b0; ps2_done = 1'b0;
    chk("pp_cnt", 32'(evt_cnt), 32'd4);
    chk("pp_ovf", 32'(ovf), 32'd0);
    chk("pp_head", 32'(evt_code), 32'h1D);
    // overflow and clear in the same cycle: set wins
    @(negedge clk);
    clr_err = 1'b1; ps2_done = 1'b1; ps2_data = 8'h3C;
    @(negedge clk);
    clr_err = 1'b0; ps2_done = 1'b0;
    chk("ovf_setwins", 32'(ovf), 32'd1);
    @(negedge clk); clr_err = 1'b1;
    @(negedge clk); clr_err = 1'b0;
    chk("ovf_clr2", 32'(ovf), 32'd0);
    pop_chk("drain0", 1'b0, 1'b0, 8'h1D);
    pop_chk("drain1", 1'b0, 1'b0, 8'h24);
    pop_chk("drain2", 1'b0, 1'b0, 8'h2D);
    pop_chk("drain3", 1'b0, 1'b0, 8'h35);
    chk("drain_empty", 32'(evt_valid), 32'd0);

    // typematic repeats
    send(8'h1C); send(8'h1C); send(8'h1C);
    send(8'hF0); send(8'h1C);
    send(8'h1C);
`ifdef PS2_KBD_TYPEMATIC_FILTER_EN
    chk("typ_cnt", 32'(evt_cnt), 32'd3);
    pop_chk("typ0", 1'b0, 1'b0, 8'h1C);
    pop_chk("typ1", 1'b0, 1'b1, 8'h1C);
    pop_chk("typ2", 1'b0, 1'b0, 8'h1C);
`else
    // only four fit; the fifth (final make) overflows
    chk("typ_cnt", 32'(evt_cnt), 32'd4);
    chk("typ_ovf", 32'(ovf), 32'd1);
    pop_chk("typ0", 1'b0, 1'b0, 8'h1C);
    pop_chk("typ1", 1'b0, 1'b0, 8'h1C);
    pop_chk("typ2", 1'b0, 1'b0, 8'h1C);
    pop_chk("typ3", 1'b0, 1'b1, 8'h1C);
`endif
    chk("typ_empty", 32'(evt_cnt), 32'd0);

    // reset mid-sequence discards the partial sequence
    send(8'hE0);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    send(8'h75);
    pop_chk("rst_mid", 1'b0, 1'b0, 8'h75);
    chk("rst_mid_ovf", 32'(ovf), 32'd0);

    chk("sys_tmo_excl", 32'(both_seen), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
